// File: rtl/operand_issue_pkg.sv
// Shared widths, slot state encoding and helpers for the operand_issue stage.
package operand_issue_pkg;

  localparam int OPW_DEF = 8;
  localparam int REGW    = 5;
  localparam int XLEN    = 32;
  localparam int NREG    = 1 << REGW;

  typedef logic [REGW-1:0] reg_idx_t;
  typedef logic [XLEN-1:0] xword_t;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

  typedef struct packed {
    xword_t   pc;
    xword_t   imm;
    reg_idx_t rs1;
    reg_idx_t rs2;
    logic     use_rs1;
    logic     use_rs2;
    reg_idx_t rd;
    logic     wb;
  } slot_fields_t;

  // x0 is never reserved or tracked.
  function automatic logic writes_reg(input logic wb, input reg_idx_t rd);
    return wb && (rd != '0);
  endfunction

endpackage

// File: rtl/operand_issue_if.sv
// Decode, register-file, writeback-snoop and execute signals of the issue stage.
interface operand_issue_if
  import operand_issue_pkg::*;
#(
  parameter int OPW = OPW_DEF
);
  logic           id_valid;
  logic           id_ready;
  xword_t         id_pc;
  logic [OPW-1:0] id_op;
  xword_t         id_imm;
  reg_idx_t       id_rs1;
  reg_idx_t       id_rs2;
  logic           id_use_rs1;
  logic           id_use_rs2;
  reg_idx_t       id_rd;
  logic           id_wb;

  reg_idx_t       rf_rs1;
  reg_idx_t       rf_rs2;
  logic           rf_rs1_valid;
  logic           rf_rs2_valid;
  xword_t         rf_rs1_data;
  xword_t         rf_rs2_data;
  reg_idx_t       rf_rd;
  logic           rf_reserve;

  logic           wb_wen;
  reg_idx_t       wb_wreg;

  logic           ex_valid;
  logic           ex_ready;
  xword_t         ex_pc;
  logic [OPW-1:0] ex_op;
  xword_t         ex_imm;
  reg_idx_t       ex_rd;
  logic           ex_wb;
  xword_t         ex_rs1_data;
  xword_t         ex_rs2_data;

  modport slave (
    input  id_valid, id_pc, id_op, id_imm, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wb,
    output id_ready,
    output rf_rs1, rf_rs2, rf_rd, rf_reserve,
    input  rf_rs1_valid, rf_rs2_valid, rf_rs1_data, rf_rs2_data,
    input  wb_wen, wb_wreg,
    output ex_valid, ex_pc, ex_op, ex_imm, ex_rd, ex_wb, ex_rs1_data, ex_rs2_data,
    input  ex_ready
  );

  modport master (
    output id_valid, id_pc, id_op, id_imm, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_wb,
    input  id_ready,
    input  rf_rs1, rf_rs2, rf_rd, rf_reserve,
    output rf_rs1_valid, rf_rs2_valid, rf_rs1_data, rf_rs2_data,
    output wb_wen, wb_wreg,
    input  ex_valid, ex_pc, ex_op, ex_imm, ex_rd, ex_wb, ex_rs1_data, ex_rs2_data,
    output ex_ready
  );
endinterface

// File: rtl/operand_issue_busy_mask.sv
// Per-register busy scoreboard (x1..x31): set on reserving issue, cleared by writeback snoop.
module issue_busy_mask
  import operand_issue_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     set_en,
  input  reg_idx_t set_idx,
  input  logic     clr_en,
  input  reg_idx_t clr_idx,
  input  reg_idx_t look_idx,
  output logic     look_busy
);

  logic [NREG-1:1] busy_q, busy_d;
  logic [NREG-1:0] cur_v, nxt_v;

  assign cur_v     = {busy_q, 1'b0};
  assign look_busy = cur_v[look_idx];

  // Set is applied after clear so a same-cycle reserve of the written register wins.
  always_comb begin
    nxt_v = cur_v;
    if (clr_en) nxt_v[clr_idx] = 1'b0;
    if (set_en) nxt_v[set_idx] = 1'b1;
    busy_d = nxt_v[NREG-1:1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

endmodule

// File: rtl/operand_issue.sv
// Issue stage: one-entry holding slot, operand read/stall, rd reservation, output register.
// Optional ISSUE_STALL_CNT_EN adds the stall_cycles counter output.
//
// state      | meaning
// SLOT_EMPTY | no instruction held; decode may load the slot
// SLOT_FULL  | instruction held, waiting on operands, WAW busy or output register
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int OPW = OPW_DEF
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           flush,
  operand_issue_if.slave bus
`ifdef ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]    stall_cycles
`endif
);

  slot_state_t    state_q, state_d;
  slot_fields_t   slot_q, slot_d;
  logic [OPW-1:0] slot_op_q, slot_op_d;

  logic           ex_valid_q, ex_valid_d;
  xword_t         ex_pc_q, ex_pc_d;
  logic [OPW-1:0] ex_op_q, ex_op_d;
  xword_t         ex_imm_q, ex_imm_d;
  reg_idx_t       ex_rd_q, ex_rd_d;
  logic           ex_wb_q, ex_wb_d;
  xword_t         ex_rs1_q, ex_rs1_d;
  xword_t         ex_rs2_q, ex_rs2_d;

  logic full, src_ok, rd_busy, waw_block, out_free, issue, accept, reserve, id_ready;

  assign full       = (state_q == SLOT_FULL);
  assign bus.rf_rs1 = slot_q.use_rs1 ? slot_q.rs1 : '0;
  assign bus.rf_rs2 = slot_q.use_rs2 ? slot_q.rs2 : '0;
  assign src_ok     = (!slot_q.use_rs1 || bus.rf_rs1_valid) &&
                      (!slot_q.use_rs2 || bus.rf_rs2_valid);
  assign waw_block  = writes_reg(slot_q.wb, slot_q.rd) && rd_busy;
  assign out_free   = !ex_valid_q || bus.ex_ready;
  assign issue      = full && src_ok && !waw_block && out_free && !flush;
  assign id_ready   = !flush && (!full || issue);
  assign accept     = bus.id_valid && id_ready;
  assign reserve    = issue && writes_reg(slot_q.wb, slot_q.rd);

  assign bus.id_ready   = id_ready;
  assign bus.rf_rd      = slot_q.rd;
  assign bus.rf_reserve = reserve;

  issue_busy_mask u_busy (
    .clk       (clk),
    .reset_n   (reset_n),
    .set_en    (reserve),
    .set_idx   (slot_q.rd),
    .clr_en    (bus.wb_wen),
    .clr_idx   (bus.wb_wreg),
    .look_idx  (slot_q.rd),
    .look_busy (rd_busy)
  );

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    slot_op_d = slot_op_q;
    case (state_q)
      SLOT_EMPTY: if (accept) state_d = SLOT_FULL;
      SLOT_FULL: begin
        if (flush)                state_d = SLOT_EMPTY;
        else if (issue && !accept) state_d = SLOT_EMPTY;
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (accept) begin
      slot_d.pc      = bus.id_pc;
      slot_d.imm     = bus.id_imm;
      slot_d.rs1     = bus.id_rs1;
      slot_d.rs2     = bus.id_rs2;
      slot_d.use_rs1 = bus.id_use_rs1;
      slot_d.use_rs2 = bus.id_use_rs2;
      slot_d.rd      = bus.id_rd;
      slot_d.wb      = bus.id_wb;
      slot_op_d      = bus.id_op;
    end
  end

  always_comb begin
    ex_valid_d = ex_valid_q;
    ex_pc_d    = ex_pc_q;
    ex_op_d    = ex_op_q;
    ex_imm_d   = ex_imm_q;
    ex_rd_d    = ex_rd_q;
    ex_wb_d    = ex_wb_q;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (issue) begin
      ex_valid_d = 1'b1;
      ex_pc_d    = slot_q.pc;
      ex_op_d    = slot_op_q;
      ex_imm_d   = slot_q.imm;
      ex_rd_d    = slot_q.rd;
      ex_wb_d    = slot_q.wb;
      ex_rs1_d   = bus.rf_rs1_data;
      ex_rs2_d   = bus.rf_rs2_data;
    end else if (bus.ex_ready) begin
      ex_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= SLOT_EMPTY;
      slot_q     <= '0;
      slot_op_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_op_q    <= '0;
      ex_imm_q   <= '0;
      ex_rd_q    <= '0;
      ex_wb_q    <= 1'b0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      slot_op_q  <= slot_op_d;
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_op_q    <= ex_op_d;
      ex_imm_q   <= ex_imm_d;
      ex_rd_q    <= ex_rd_d;
      ex_wb_q    <= ex_wb_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
    end
  end

  assign bus.ex_valid    = ex_valid_q;
  assign bus.ex_pc       = ex_pc_q;
  assign bus.ex_op       = ex_op_q;
  assign bus.ex_imm      = ex_imm_q;
  assign bus.ex_rd       = ex_rd_q;
  assign bus.ex_wb       = ex_wb_q;
  assign bus.ex_rs1_data = ex_rs1_q;
  assign bus.ex_rs2_data = ex_rs2_q;

`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (full && !issue && !flush) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue with a register-file model and an in-order scoreboard.
module tb_operand_issue;
  import operand_issue_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        wb;
    logic [31:0] d1;
    logic [31:0] d2;
  } exp_t;

  logic clk;
  logic reset_n;
  logic flush;
  logic rf_restore;
  logic [31:0] wb_data;
  logic [31:0] rf_val [32];
  logic        rf_vld [32];
  exp_t        exq [$];
  logic [4:0]  rsvq [$];
  int checks;
  int failures;
`ifdef ISSUE_STALL_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] stall_snap;
`endif

  operand_issue_if #(.OPW(8)) bus ();

  operand_issue #(.OPW(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef ISSUE_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] init_val(input int i);
    return 32'h100 + 32'(i);
  endfunction

  // Register file: x0 always valid/zero, same-cycle writeback bypasses to the read ports.
  always_comb begin
    bus.rf_rs1_valid = (bus.rf_rs1 == 5'd0) || rf_vld[bus.rf_rs1] ||
                       (bus.wb_wen && bus.wb_wreg == bus.rf_rs1);
    bus.rf_rs2_valid = (bus.rf_rs2 == 5'd0) || rf_vld[bus.rf_rs2] ||
                       (bus.wb_wen && bus.wb_wreg == bus.rf_rs2);
    bus.rf_rs1_data  = (bus.rf_rs1 == 5'd0) ? 32'd0 :
                       (bus.wb_wen && bus.wb_wreg == bus.rf_rs1) ? wb_data : rf_val[bus.rf_rs1];
    bus.rf_rs2_data  = (bus.rf_rs2 == 5'd0) ? 32'd0 :
                       (bus.wb_wen && bus.wb_wreg == bus.rf_rs2) ? wb_data : rf_val[bus.rf_rs2];
  end

  always @(posedge clk) begin
    if (rf_restore) begin
      for (int i = 0; i < 32; i++) begin
        rf_vld[i] <= 1'b1;
        rf_val[i] <= init_val(i);
      end
    end else begin
      if (bus.wb_wen) begin
        rf_vld[bus.wb_wreg] <= 1'b1;
        rf_val[bus.wb_wreg] <= wb_data;
      end
      if (bus.rf_reserve) rf_vld[bus.rf_rd] <= 1'b0;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: execute handshakes and reserve strobes, in order.
  always @(negedge clk) begin : mon
    exp_t e;
    logic [4:0] r;
    if (reset_n) begin
      if (bus.ex_valid && bus.ex_ready) begin
        check1("ex_expected_pending", exq.size() > 0, 1'b1);
        if (exq.size() > 0) begin
          e = exq.pop_front();
          check32("ex_pc", bus.ex_pc, e.pc);
          check32("ex_op", {24'd0, bus.ex_op}, {24'd0, e.op});
          check32("ex_imm", bus.ex_imm, e.imm);
          check32("ex_rd", {27'd0, bus.ex_rd}, {27'd0, e.rd});
          check1("ex_wb", bus.ex_wb, e.wb);
          check32("ex_rs1_data", bus.ex_rs1_data, e.d1);
          check32("ex_rs2_data", bus.ex_rs2_data, e.d2);
        end
      end
      if (bus.rf_reserve) begin
        check1("rsv_expected_pending", rsvq.size() > 0, 1'b1);
        if (rsvq.size() > 0) begin
          r = rsvq.pop_front();
          check32("rsv_rd", {27'd0, bus.rf_rd}, {27'd0, r});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.id_valid = 1'b0;
  endtask

  task automatic offer(input logic [31:0] pc, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                       input logic wb, input logic [31:0] d1, input logic [31:0] d2);
    exp_t e;
    bus.id_valid   = 1'b1;
    bus.id_pc      = pc;
    bus.id_op      = pc[7:0] ^ 8'h5a;
    bus.id_imm     = ~pc;
    bus.id_rs1     = rs1;
    bus.id_use_rs1 = u1;
    bus.id_rs2     = rs2;
    bus.id_use_rs2 = u2;
    bus.id_rd      = rd;
    bus.id_wb      = wb;
    e.pc  = pc;
    e.op  = pc[7:0] ^ 8'h5a;
    e.imm = ~pc;
    e.rd  = rd;
    e.wb  = wb;
    e.d1  = d1;
    e.d2  = d2;
    exq.push_back(e);
    if (wb && rd != 5'd0) rsvq.push_back(rd);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset_n = 1'b0;
    flush = 1'b0;
    rf_restore = 1'b1;
    wb_data = 32'd0;
    bus.wb_wen = 1'b0;
    bus.wb_wreg = 5'd0;
    bus.ex_ready = 1'b0;
    bus.id_valid = 1'b0;
    bus.id_pc = 32'd0;
    bus.id_op = 8'd0;
    bus.id_imm = 32'd0;
    bus.id_rs1 = 5'd0;
    bus.id_rs2 = 5'd0;
    bus.id_use_rs1 = 1'b0;
    bus.id_use_rs2 = 1'b0;
    bus.id_rd = 5'd0;
    bus.id_wb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    at_neg();
    check1("rst_ex_valid", bus.ex_valid, 1'b0);
    check1("rst_id_ready", bus.id_ready, 1'b1);
    check1("rst_reserve", bus.rf_reserve, 1'b0);
    check32("rst_ex_pc", bus.ex_pc, 32'd0);
    check32("rst_ex_rs1", bus.ex_rs1_data, 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    check32("rst_stall_cnt", stall_cycles, 32'd0);
`endif
    tick();
    reset_n = 1'b1;
    rf_restore = 1'b0;

    // 1: independent back-to-back adds
    bus.ex_ready = 1'b1;
    offer(32'h1000, 5'd2, 1'b1, 5'd3, 1'b1, 5'd1, 1'b1, init_val(2), init_val(3));
    at_neg();
    check1("t1_a_ready", bus.id_ready, 1'b1);
    check1("t1_a_not_yet", bus.ex_valid, 1'b0);
    tick();
    offer(32'h1004, 5'd5, 1'b1, 5'd6, 1'b1, 5'd4, 1'b1, init_val(5), init_val(6));
    at_neg();
    check1("t1_b2b_ready", bus.id_ready, 1'b1);
    check1("t1_a_reserve", bus.rf_reserve, 1'b1);
    check1("t1_a_latency", bus.ex_valid, 1'b0);
    tick();
    idle();
    at_neg();
    check1("t1_a_valid", bus.ex_valid, 1'b1);
    check32("t1_a_pc", bus.ex_pc, 32'h1000);
    tick();
    at_neg();
    check1("t1_b_valid", bus.ex_valid, 1'b1);
    check32("t1_b_pc", bus.ex_pc, 32'h1004);
    tick();

    // 2: RAW on x1 released by same-cycle writeback; then rd=0 with unused rs2
    offer(32'h2000, 5'd1, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 32'h1234, init_val(2));
    at_neg();
    check1("t2_c_ready", bus.id_ready, 1'b1);
    tick();
`ifdef ISSUE_STALL_CNT_EN
    stall_snap = stall_cycles;
`endif
    offer(32'h2004, 5'd10, 1'b1, 5'd3, 1'b0, 5'd0, 1'b1, init_val(10), 32'd0);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check1("t2_stall_ready", bus.id_ready, 1'b0);
      check1("t2_stall_exv", bus.ex_valid, 1'b0);
      tick();
    end
    bus.wb_wen = 1'b1;
    bus.wb_wreg = 5'd1;
    wb_data = 32'h1234;
    at_neg();
    check1("t2_wb_issue", bus.id_ready, 1'b1);
    tick();
    idle();
    bus.wb_wen = 1'b0;
    at_neg();
    check32("t2_unused_rs2_addr", {27'd0, bus.rf_rs2}, 32'd0);
    check1("t2_d_issue", bus.id_ready, 1'b1);
    check1("t2_rd0_no_reserve", bus.rf_reserve, 1'b0);
`ifdef ISSUE_STALL_CNT_EN
    check32("t2_stall_count", stall_cycles - stall_snap, 32'd3);
`endif
    tick();
    at_neg();
    check32("t2_d_pc", bus.ex_pc, 32'h2004);
    tick();

    // 3: WAW on x7
    offer(32'h3000, 5'd11, 1'b1, 5'd12, 1'b1, 5'd7, 1'b1, init_val(11), init_val(12));
    at_neg();
    check1("t3_e_ready", bus.id_ready, 1'b1);
    tick();
    offer(32'h3004, 5'd13, 1'b1, 5'd14, 1'b1, 5'd7, 1'b1, init_val(13), init_val(14));
    at_neg();
    check1("t3_f_accept", bus.id_ready, 1'b1);
    tick();
    idle();
    for (int k = 0; k < 2; k++) begin
      at_neg();
      check1("t3_waw_hold", bus.id_ready, 1'b0);
      check1("t3_waw_no_rsv", bus.rf_reserve, 1'b0);
      tick();
    end
    bus.wb_wen = 1'b1;
    bus.wb_wreg = 5'd7;
    wb_data = 32'h77;
    at_neg();
    check1("t3_wb_cycle_hold", bus.id_ready, 1'b0);
    tick();
    wb_data = 32'h78;
    at_neg();
    check1("t3_f_issue", bus.id_ready, 1'b1);
    check1("t3_f_reserve", bus.rf_reserve, 1'b1);
    tick();
    bus.wb_wen = 1'b0;
    at_neg();
    check1("t3_busy7_set_wins", dut.u_busy.busy_q[7], 1'b1);
    tick();
    bus.wb_wen = 1'b1;
    bus.wb_wreg = 5'd7;
    wb_data = 32'h79;
    tick();
    bus.wb_wen = 1'b0;
    at_neg();
    check1("t3_busy7_cleared", dut.u_busy.busy_q[7], 1'b0);
    tick();

    // 4: execute backpressure
    bus.ex_ready = 1'b0;
    offer(32'h4000, 5'd14, 1'b1, 5'd15, 1'b1, 5'd13, 1'b1, init_val(14), init_val(15));
    at_neg();
    check1("t4_h_ready", bus.id_ready, 1'b1);
    tick();
    offer(32'h4004, 5'd17, 1'b1, 5'd18, 1'b1, 5'd16, 1'b1, init_val(17), init_val(18));
    at_neg();
    check1("t4_i_accept", bus.id_ready, 1'b1);
    tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check1("t4_hold_valid", bus.ex_valid, 1'b1);
      check32("t4_hold_pc", bus.ex_pc, 32'h4000);
      check32("t4_hold_rs1", bus.ex_rs1_data, init_val(14));
      check1("t4_hold_id_ready", bus.id_ready, 1'b0);
      tick();
    end
    bus.ex_ready = 1'b1;
    at_neg();
    check1("t4_i_issue", bus.id_ready, 1'b1);
    tick();
    at_neg();
    check32("t4_i_pc", bus.ex_pc, 32'h4004);
    tick();
    at_neg();
    check1("t4_drained", bus.ex_valid, 1'b0);
    tick();

    // 5: flush with slot full and output valid
    bus.ex_ready = 1'b0;
    offer(32'h5000, 5'd20, 1'b1, 5'd21, 1'b1, 5'd19, 1'b1, init_val(20), init_val(21));
    at_neg();
    check1("t5_k_ready", bus.id_ready, 1'b1);
    tick();
    offer(32'h5004, 5'd2, 1'b1, 5'd3, 1'b1, 5'd22, 1'b1, init_val(2), init_val(3));
    at_neg();
    check1("t5_l_accept", bus.id_ready, 1'b1);
    tick();
    bus.id_valid = 1'b1;
    flush = 1'b1;
    at_neg();
    check1("t5_flush_no_rsv", bus.rf_reserve, 1'b0);
    check1("t5_flush_id_ready", bus.id_ready, 1'b0);
    tick();
    flush = 1'b0;
    idle();
    exq.delete();
    rsvq.delete();
    at_neg();
    check1("t5_ex_killed", bus.ex_valid, 1'b0);
    check1("t5_slot_empty", bus.id_ready, 1'b1);
    check1("t5_busy19_kept", dut.u_busy.busy_q[19], 1'b1);
    tick();
    offer(32'h5008, 5'd20, 1'b1, 5'd19, 1'b0, 5'd23, 1'b1, init_val(20), 32'd0);
    at_neg();
    check1("t5_m_ready", bus.id_ready, 1'b1);
    tick();
    idle();
    at_neg();
    check32("t5_m_rs2_addr", {27'd0, bus.rf_rs2}, 32'd0);
    check1("t5_m_unused_no_stall", bus.id_ready, 1'b1);
    tick();

    // 6: reset mid-stall
    offer(32'h6000, 5'd19, 1'b1, 5'd2, 1'b1, 5'd24, 1'b1, init_val(19), init_val(2));
    at_neg();
    check1("t6_n_ready", bus.id_ready, 1'b1);
    tick();
    idle();
    at_neg();
    check1("t6_stalled", bus.id_ready, 1'b0);
    check1("t6_m_valid", bus.ex_valid, 1'b1);
    tick();
    reset_n = 1'b0;
    rf_restore = 1'b1;
    #1;
    check1("t6_rst_ex_valid", bus.ex_valid, 1'b0);
    check1("t6_rst_reserve", bus.rf_reserve, 1'b0);
    check32("t6_rst_busy", {1'b0, dut.u_busy.busy_q}, 32'd0);
`ifdef ISSUE_STALL_CNT_EN
    check32("t6_rst_stall_cnt", stall_cycles, 32'd0);
`endif
    exq.delete();
    rsvq.delete();
    tick();
    tick();
    reset_n = 1'b1;
    rf_restore = 1'b0;
    at_neg();
    check1("t6_post_id_ready", bus.id_ready, 1'b1);
    check1("t6_post_ex_valid", bus.ex_valid, 1'b0);
    tick();

    bus.ex_ready = 1'b1;
    offer(32'h7000, 5'd19, 1'b1, 5'd20, 1'b1, 5'd25, 1'b1, init_val(19), init_val(20));
    at_neg();
    check1("t7_q_ready", bus.id_ready, 1'b1);
    tick();
    idle();
    for (int k = 0; k < 10 && exq.size() > 0; k++) tick();
    at_neg();
    check32("end_exq_empty", 32'(exq.size()), 32'd0);
    check32("end_rsvq_empty", 32'(rsvq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
